// File: rtl/axs_rd_pkg.sv
// Shared encodings for the s0 read-out slave: FSM states, decoded byte addresses, AXI response codes.
package axs_rd_pkg;

  typedef enum logic [3:0] {
    ST_INIT   = 4'b0001,
    ST_IDLE   = 4'b0010,
    ST_FETCH  = 4'b0100,
    ST_RVALID = 4'b1000
  } rd_state_t;

  localparam logic [7:0] ADDR_VARINT_DATA = 8'h00;
  localparam logic [7:0] ADDR_VARINT_STAT = 8'h04;
  localparam logic [7:0] ADDR_RAW_DATA    = 8'hF0;
  localparam logic [7:0] ADDR_RAW_STAT    = 8'hF4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rd_timeout_ctr.sv
// Consecutive-cycle counter: expired fires on the TIMEOUT_CYC-th enabled cycle since the last clear.
// Latency: combinational expired from registered count; no backpressure.
module rd_timeout_ctr #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_cnt_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] r_cnt;

  assign o_expired = i_cnt_en && (r_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_cnt_en && !o_expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/axs_read_out_fsm.sv
// AXI4 read slave draining the varint_out / raw_data_out FIFOs; AR->first R = 2 cycles, 1 bubble per beat.
// R held until rready, one burst in flight; AXS_RD_TIMEOUT_EN adds an empty-wait SLVERR timeout.
module axs_read_out_fsm
  import axs_rd_pkg::*;
#(
  parameter int FIFO_AW     = 10,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         axs_s0_arid,
  input  logic [31:0]        axs_s0_araddr,
  input  logic [7:0]         axs_s0_arlen,
  input  logic [2:0]         axs_s0_arsize,
  input  logic [1:0]         axs_s0_arburst,
  input  logic               axs_s0_arvalid,
  output logic               axs_s0_arready,
  output logic [3:0]         axs_s0_rid,
  output logic [31:0]        axs_s0_rdata,
  output logic [1:0]         axs_s0_rresp,
  output logic               axs_s0_rlast,
  output logic               axs_s0_rvalid,
  input  logic               axs_s0_rready,
  input  logic               varint_out_fifo_empty,
  input  logic [31:0]        varint_out_fifo_q,
  input  logic [FIFO_AW:0]   varint_out_fifo_usedw,
  output logic               varint_out_fifo_pop,
  input  logic               raw_data_out_fifo_empty,
  input  logic [31:0]        raw_data_out_fifo_q,
  input  logic [FIFO_AW:0]   raw_data_out_fifo_usedw,
  output logic               raw_data_out_fifo_pop
);

  rd_state_t   r_state, w_state_nxt;
  logic [3:0]  r_rid;
  logic [7:0]  r_addr;
  logic [7:0]  r_beats_left;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;

  logic        w_is_vdata, w_is_rdata, w_is_vstat, w_is_rstat, w_is_data;
  logic        w_fifo_empty, w_timeout, w_ld, w_dec, w_unused_ok;
  logic [31:0] w_fifo_q, w_rdata_nxt;
  logic [1:0]  w_rresp_nxt;

  assign w_unused_ok = ^{axs_s0_araddr[31:8], axs_s0_arsize, axs_s0_arburst};

  assign w_is_vdata   = (r_addr == ADDR_VARINT_DATA);
  assign w_is_rdata   = (r_addr == ADDR_RAW_DATA);
  assign w_is_vstat   = (r_addr == ADDR_VARINT_STAT);
  assign w_is_rstat   = (r_addr == ADDR_RAW_STAT);
  assign w_is_data    = w_is_vdata || w_is_rdata;
  assign w_fifo_empty = w_is_vdata ? varint_out_fifo_empty : raw_data_out_fifo_empty;
  assign w_fifo_q     = w_is_vdata ? varint_out_fifo_q : raw_data_out_fifo_q;

`ifdef AXS_RD_TIMEOUT_EN
  rd_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rd_timeout_ctr (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (r_state != ST_FETCH),
    .i_cnt_en  ((r_state == ST_FETCH) && w_is_data && w_fifo_empty),
    .o_expired (w_timeout)
  );
`else
  logic w_unused_to;
  assign w_timeout   = 1'b0;
  assign w_unused_to = ^32'(TIMEOUT_CYC);
`endif

  always_comb begin
    w_state_nxt           = r_state;
    w_ld                  = 1'b0;
    w_dec                 = 1'b0;
    w_rdata_nxt           = '0;
    w_rresp_nxt           = RESP_OKAY;
    varint_out_fifo_pop   = 1'b0;
    raw_data_out_fifo_pop = 1'b0;
    unique case (r_state)
      ST_INIT: w_state_nxt = ST_IDLE;
      ST_IDLE: if (axs_s0_arvalid) w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (w_is_vstat) begin
          w_ld        = 1'b1;
          w_rdata_nxt = {varint_out_fifo_empty, {(30-FIFO_AW){1'b0}}, varint_out_fifo_usedw};
          w_state_nxt = ST_RVALID;
        end else if (w_is_rstat) begin
          w_ld        = 1'b1;
          w_rdata_nxt = {raw_data_out_fifo_empty, {(30-FIFO_AW){1'b0}}, raw_data_out_fifo_usedw};
          w_state_nxt = ST_RVALID;
        end else if (!w_is_data) begin
          w_ld        = 1'b1;
          w_rresp_nxt = RESP_DECERR;
          w_state_nxt = ST_RVALID;
        end else if (!w_fifo_empty) begin
          // Show-ahead FIFO: head word is captured on the same edge that pops it.
          w_ld                  = 1'b1;
          w_rdata_nxt           = w_fifo_q;
          varint_out_fifo_pop   = w_is_vdata;
          raw_data_out_fifo_pop = w_is_rdata;
          w_state_nxt           = ST_RVALID;
        end else if (w_timeout) begin
          w_ld        = 1'b1;
          w_rresp_nxt = RESP_SLVERR;
          w_state_nxt = ST_RVALID;
        end
      end
      ST_RVALID: begin
        if (axs_s0_rready) begin
          w_dec       = (r_beats_left != 8'd0);
          w_state_nxt = (r_beats_left == 8'd0) ? ST_IDLE : ST_FETCH;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_INIT;
      r_rid        <= '0;
      r_addr       <= '0;
      r_beats_left <= '0;
      r_rdata      <= '0;
      r_rresp      <= RESP_OKAY;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && axs_s0_arvalid) begin
        r_rid        <= axs_s0_arid;
        r_addr       <= axs_s0_araddr[7:0];
        r_beats_left <= axs_s0_arlen;
      end else if (w_dec) begin
        r_beats_left <= r_beats_left - 8'd1;
      end
      if (w_ld) begin
        r_rdata <= w_rdata_nxt;
        r_rresp <= w_rresp_nxt;
      end
    end
  end

  assign axs_s0_arready = (r_state == ST_IDLE);
  assign axs_s0_rvalid  = (r_state == ST_RVALID);
  assign axs_s0_rlast   = (r_state == ST_RVALID) && (r_beats_left == 8'd0);
  assign axs_s0_rid     = r_rid;
  assign axs_s0_rdata   = r_rdata;
  assign axs_s0_rresp   = r_rresp;

endmodule

// File: tb/tb_axs_read_out_fsm.sv
// Directed bench for axs_read_out_fsm with behavioural show-ahead FIFO models on both result queues.
module tb_axs_read_out_fsm;

`ifdef AXS_RD_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 1024;
`endif
  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid;
  logic        rready = 1'b1;
  logic        v_empty, v_pop, r_empty, r_pop;
  logic [31:0] v_q, r_q;
  logic [AW:0] v_usedw, r_usedw;

  logic [31:0] v_mem [16];
  logic [31:0] r_mem [16];
  int v_wr, v_rd, r_wr, r_rd, v_pops, r_pops, viol;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign v_empty = (v_wr == v_rd);
  assign v_q     = v_mem[v_rd % 16];
  assign v_usedw = (AW+1)'(v_wr - v_rd);
  assign r_empty = (r_wr == r_rd);
  assign r_q     = r_mem[r_rd % 16];
  assign r_usedw = (AW+1)'(r_wr - r_rd);

  always @(posedge clk) begin
    if (v_pop) begin
      v_rd   <= v_rd + 1;
      v_pops <= v_pops + 1;
      if (v_empty || rvalid) viol <= viol + 1;
    end
    if (r_pop) begin
      r_rd   <= r_rd + 1;
      r_pops <= r_pops + 1;
      if (r_empty || rvalid) viol <= viol + 1;
    end
  end

  axs_read_out_fsm #(.FIFO_AW(AW), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .axs_s0_arid             (arid),
    .axs_s0_araddr           (araddr),
    .axs_s0_arlen            (arlen),
    .axs_s0_arsize           (arsize),
    .axs_s0_arburst          (arburst),
    .axs_s0_arvalid          (arvalid),
    .axs_s0_arready          (arready),
    .axs_s0_rid              (rid),
    .axs_s0_rdata            (rdata),
    .axs_s0_rresp            (rresp),
    .axs_s0_rlast            (rlast),
    .axs_s0_rvalid           (rvalid),
    .axs_s0_rready           (rready),
    .varint_out_fifo_empty   (v_empty),
    .varint_out_fifo_q       (v_q),
    .varint_out_fifo_usedw   (v_usedw),
    .varint_out_fifo_pop     (v_pop),
    .raw_data_out_fifo_empty (r_empty),
    .raw_data_out_fifo_q     (r_q),
    .raw_data_out_fifo_usedw (r_usedw),
    .raw_data_out_fifo_pop   (r_pop)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_v(input logic [31:0] d);
    v_mem[v_wr % 16] = d;
    v_wr = v_wr + 1;
  endtask

  task automatic push_r(input logic [31:0] d);
    r_mem[r_wr % 16] = d;
    r_wr = r_wr + 1;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [7:0] a, input logic [7:0] len);
    int n = 0;
    @(negedge clk);
    arid = id; araddr = {24'hABCDE0, a}; arlen = len; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ar_ready", arready, 1);
    @(posedge clk);
    #1 arvalid = 1'b0;
  endtask

  // lat = clock edges from the previous handshake edge to the edge where rvalid is first sampled high
  task automatic beat(input string tag, input logic [31:0] ed, input logic [1:0] er,
                      input logic el, input logic [3:0] eid, input int elat);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rvalid && lat < 40);
    chk({tag, "_rvalid"}, rvalid, 1);
    chk({tag, "_rdata"}, rdata, ed);
    chk({tag, "_rresp"}, rresp, er);
    chk({tag, "_rlast"}, rlast, el);
    chk({tag, "_rid"}, rid, eid);
    if (elat > 0) chk({tag, "_lat"}, lat, elat);
    @(posedge clk);
    #1;
  endtask

  int p0;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rid", rid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_pop", {v_pop, r_pop}, 0);
    @(negedge clk) reset = 1'b0;
    #1 chk("init_arready", arready, 0);
    @(posedge clk);
    #1 chk("idle_arready", arready, 1);

    // varint data burst of 3
    push_v(32'hA1); push_v(32'hB2); push_v(32'hC3);
    p0 = v_pops;
    do_ar(4'h5, 8'h00, 8'd2);
    chk("t1_arready_busy", arready, 0);
    beat("t1_b1", 32'hA1, 2'b00, 1'b0, 4'h5, 2);
    beat("t1_b2", 32'hB2, 2'b00, 1'b0, 4'h5, 2);
    beat("t1_b3", 32'hC3, 2'b00, 1'b1, 4'h5, 2);
    chk("t1_pops", v_pops - p0, 3);

    // raw status with 5 words queued, then drain them
    for (int i = 1; i <= 5; i++) push_r(32'h10 + i);
    p0 = r_pops;
    do_ar(4'h2, 8'hF4, 8'd0);
    beat("t2_stat", 32'h0000_0005, 2'b00, 1'b1, 4'h2, 2);
    chk("t2_pops", r_pops - p0, 0);
    do_ar(4'h7, 8'hF0, 8'd4);
    for (int i = 1; i <= 5; i++) beat("t2_drain", 32'h10 + i, 2'b00, (i == 5), 4'h7, 2);
    do_ar(4'h7, 8'hF4, 8'd0);
    beat("t2_stat_empty", 32'h8000_0000, 2'b00, 1'b1, 4'h7, 2);
    do_ar(4'h1, 8'h04, 8'd0);
    beat("t2_vstat_empty", 32'h8000_0000, 2'b00, 1'b1, 4'h1, 2);

    // unmapped address
    p0 = v_pops + r_pops;
    do_ar(4'hA, 8'h40, 8'd1);
    beat("t3_b1", 32'h0, 2'b11, 1'b0, 4'hA, 2);
    beat("t3_b2", 32'h0, 2'b11, 1'b1, 4'hA, 2);
    chk("t3_pops", v_pops + r_pops - p0, 0);

    // rready stall on beat 1
    push_v(32'hDEAD_0001); push_v(32'hDEAD_0002);
    p0 = v_pops;
    rready = 1'b0;
    do_ar(4'h3, 8'h00, 8'd1);
    for (int n = 0; n < 10 && !rvalid; n++) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("t4_hold_rvalid", rvalid, 1);
      chk("t4_hold_rdata", rdata, 32'hDEAD_0001);
      chk("t4_hold_pops", v_pops - p0, 1);
      @(negedge clk);
    end
    rready = 1'b1;
    @(posedge clk);
    #1;
    beat("t4_b2", 32'hDEAD_0002, 2'b00, 1'b1, 4'h3, 2);
    chk("t4_pops", v_pops - p0, 2);

    // empty raw FIFO: wait, then push
    do_ar(4'h4, 8'hF0, 8'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t4_empty_wait", rvalid, 0);
    end
    push_r(32'hCAFE_F00D);
    beat("t4_late", 32'hCAFE_F00D, 2'b00, 1'b1, 4'h4, 0);

`ifdef AXS_RD_TIMEOUT_EN
    p0 = v_pops;
    do_ar(4'h6, 8'h00, 8'd0);
    beat("t5_timeout", 32'h0, 2'b10, 1'b1, 4'h6, TO_CYC + 1);
    chk("t5_pops", v_pops - p0, 0);
`endif

    // reset in the middle of a 4-beat burst
    for (int i = 1; i <= 4; i++) push_v(32'h60 + i);
    p0 = v_pops;
    do_ar(4'h9, 8'h00, 8'd3);
    beat("t6_b1", 32'h61, 2'b00, 1'b0, 4'h9, 2);
    for (int n = 0; n < 10 && !rvalid; n++) @(negedge clk);
    chk("t6_b2_rdata", rdata, 32'h62);
    reset = 1'b1;
    #1;
    chk("t6_rst_rvalid", rvalid, 0);
    chk("t6_rst_rlast", rlast, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1 chk("t6_rel_arready", arready, 0);
    @(posedge clk);
    #1 chk("t6_idle_arready", arready, 1);
    chk("t6_pops", v_pops - p0, 2);

    chk("pop_violations", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
